// File: rtl/mem_io_unit_pkg.sv
// Shared opcode, sub-op and FSM encodings for the pP 8-bit core.
// Latency: none (definitions only); backpressure: n/a.
package pp_defs;

    localparam logic [3:0] KIND_ALU     = 4'b0000;
    localparam logic [3:0] KIND_ALU_IMM = 4'b0001;
    localparam logic [3:0] KIND_BRANCH  = 4'b0010;
    localparam logic [3:0] KIND_MEM_IO  = 4'b0011;
    localparam logic [3:0] KIND_JUMP    = 4'b0100;

    localparam logic [1:0] FN2_LOAD  = 2'b00;
    localparam logic [1:0] FN2_STORE = 2'b01;
    localparam logic [1:0] FN2_IN    = 2'b10;
    localparam logic [1:0] FN2_OUT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_IN_WAIT  = 2'b01,
        ST_OUT_WAIT = 2'b10,
        ST_DONE     = 2'b11
    } mio_state_e;

    function automatic logic is_mem_op(input logic [3:0] kind);
        return kind == KIND_MEM_IO;
    endfunction

endpackage

// File: rtl/mem_io_unit_data_ram.sv
// Single-port byte RAM, synchronous write and read-enabled registered read, no reset.
// Latency: read data valid after the enabled edge and held until the next read; backpressure: none.
module data_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              ck,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wr_dat,
    output logic [7:0]        rd_dat
);

    logic [7:0] mem [2**ADDR_W];
    logic [7:0] rd_d;
    logic [7:0] rd_q;

    always_comb begin
        rd_d = rd_q;
        if (re) begin
            rd_d = mem[addr];
        end
    end

    always_ff @(posedge ck) begin
        if (we) begin
            mem[addr] <= wr_dat;
        end
        rd_q <= rd_d;
    end

    assign rd_dat = rd_q;

endmodule

// File: rtl/mem_io_unit.sv
// Data-side load/store and I/O port unit: RAM access plus valid/ready port handshakes.
// Latency: load/IN result registered one edge after access/capture; backpressure: stall while a port transfer waits.
module mem_io_unit
    import pp_defs::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              ck,
    input  logic              res,
    input  logic              ck2,
    input  logic [3:0]        kind,
    input  logic [1:0]        fn2,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        store_d,
    output logic [7:0]        load_d,
    output logic              stall,
    input  logic [7:0]        io_in_d,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    output logic [7:0]        io_out_d,
    output logic              io_out_valid,
    input  logic              io_out_ack
);

    mio_state_e state_d, state_q;
    logic [7:0] in_byte_d, in_byte_q;
    logic       load_sel_d, load_sel_q;
    logic [7:0] out_byte_d, out_byte_q;
    logic       ram_re;
    logic       ram_we;
    logic [7:0] ram_rd_dat;
    logic       mem_op;

    assign mem_op = is_mem_op(kind);
    assign ram_we = mem_op && (fn2 == FN2_STORE) && !ck2;

    data_ram #(
        .ADDR_W (ADDR_W)
    ) u_data_ram (
        .ck     (ck),
        .we     (ram_we),
        .re     (ram_re),
        .addr   (addr),
        .wr_dat (store_d),
        .rd_dat (ram_rd_dat)
    );

    always_comb begin
        state_d    = state_q;
        in_byte_d  = in_byte_q;
        load_sel_d = load_sel_q;
        out_byte_d = out_byte_q;
        ram_re     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op && ck2) begin
                    case (fn2)
                        FN2_LOAD: begin
                            ram_re     = 1'b1;
                            load_sel_d = 1'b0;
                        end
                        FN2_IN: begin
                            state_d = ST_IN_WAIT;
                        end
                        FN2_OUT: begin
                            out_byte_d = store_d;
                            state_d    = ST_OUT_WAIT;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_IN_WAIT: begin
                if (io_in_valid) begin
                    in_byte_d  = io_in_d;
                    load_sel_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_OUT_WAIT: begin
                if (io_out_ack) begin
                    state_d = ST_DONE;
                end
            end
            // One dead cycle so a still-high ck2 cannot restart the same port op.
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            state_q    <= ST_IDLE;
            in_byte_q  <= 8'h00;
            load_sel_q <= 1'b1;
            out_byte_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            in_byte_q  <= in_byte_d;
            load_sel_q <= load_sel_d;
            out_byte_q <= out_byte_d;
        end
    end

    // Both mux inputs and the select are registers, so load_d only moves at clock edges.
    assign load_d       = load_sel_q ? in_byte_q : ram_rd_dat;
    assign io_out_d     = out_byte_q;
    assign io_in_ready  = (state_q == ST_IN_WAIT);
    assign io_out_valid = (state_q == ST_OUT_WAIT);
    assign stall        = (state_q == ST_IN_WAIT) || (state_q == ST_OUT_WAIT);

endmodule

// File: tb/tb_mem_io_unit.sv
// Scoreboard bench for mem_io_unit: transaction stimulus feeds expectation queues, a monitor checks them.
// Latency: n/a; backpressure: the bench models the sequencer holding ck2 while stall is high.
module tb_mem_io_unit;

    logic       ck;
    logic       res;
    logic       ck2;
    logic [3:0] kind;
    logic [1:0] fn2;
    logic [7:0] addr;
    logic [7:0] store_d;
    logic [7:0] load_d;
    logic       stall;
    logic [7:0] io_in_d;
    logic       io_in_valid;
    logic       io_in_ready;
    logic [7:0] io_out_d;
    logic       io_out_valid;
    logic       io_out_ack;

    mem_io_unit #(.ADDR_W(8)) dut (
        .ck           (ck),
        .res          (res),
        .ck2          (ck2),
        .kind         (kind),
        .fn2          (fn2),
        .addr         (addr),
        .store_d      (store_d),
        .load_d       (load_d),
        .stall        (stall),
        .io_in_d      (io_in_d),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_out_d     (io_out_d),
        .io_out_valid (io_out_valid),
        .io_out_ack   (io_out_ack)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_load_q [$];
    logic [7:0] exp_out_q  [$];
    int         exp_stall_q[$];
    logic       ld_strobe = 1'b0;

    logic [7:0] ram_model [256];
    logic [7:0] wr_list [$];
    logic [7:0] last_load;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic underflow(input string name);
        tests++;
        fails++;
        $display("FAIL %s: DUT produced an unexpected response at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic set_idle();
        ck2         = 1'b0;
        kind        = 4'b0000;
        fn2         = 2'b00;
        io_in_valid = 1'b0;
        io_out_ack  = 1'b0;
    endtask

    task automatic do_store(input logic [7:0] a, input logic [7:0] d);
        ck2 = 1'b0; kind = 4'b0011; fn2 = 2'b01; addr = a; store_d = d;
        tick();
        set_idle();
        ram_model[a] = d;
        wr_list.push_back(a);
    endtask

    task automatic do_load(input logic [7:0] a);
        ck2 = 1'b1; kind = 4'b0011; fn2 = 2'b00; addr = a;
        tick();
        set_idle();
        last_load = ram_model[a];
        exp_load_q.push_back(last_load);
        ld_strobe = 1'b1;
        tick();
        ld_strobe = 1'b0;
    endtask

    task automatic do_in(input int delay, input logic [7:0] d);
        exp_stall_q.push_back(delay + 1);
        exp_load_q.push_back(d);
        ck2 = 1'b1; kind = 4'b0011; fn2 = 2'b10;
        io_in_d = d; io_in_valid = (delay == 0);
        tick();
        io_in_valid = 1'b0;
        io_in_d     = 8'($urandom);
        repeat (delay) tick();
        io_in_valid = 1'b1; io_in_d = d;
        tick();
        // Done cycle: sequencer still shows the IN and the peripheral keeps offering other data.
        io_in_d = ~d;
        tick();
        set_idle();
        last_load = d;
        exp_load_q.push_back(d);
        ld_strobe = 1'b1;
        tick();
        ld_strobe = 1'b0;
    endtask

    task automatic do_out(input logic [7:0] d, input int delay);
        exp_stall_q.push_back(delay + 1);
        exp_out_q.push_back(d);
        ck2 = 1'b1; kind = 4'b0011; fn2 = 2'b11; store_d = d; io_out_ack = 1'b0;
        tick();
        store_d = ~d;
        repeat (delay) tick();
        io_out_ack = 1'b1;
        tick();
        io_out_ack = 1'b0;
        tick();
        set_idle();
    endtask

    task automatic do_bad(input logic is_store, input logic [7:0] a, input logic [7:0] d);
        logic [3:0] k;
        k = 4'($urandom_range(0, 15));
        if (k == 4'b0011) k = 4'b0000;
        kind = k; addr = a; store_d = d;
        ck2 = !is_store;
        fn2 = is_store ? 2'b01 : 2'($urandom);
        tick();
        set_idle();
        if (!is_store) begin
            exp_load_q.push_back(last_load);
            ld_strobe = 1'b1;
            tick();
            ld_strobe = 1'b0;
        end
    endtask

    // Monitor: pops expectations whenever the DUT completes a response.
    initial begin
        logic in_chk;
        int   stall_cnt;
        int   e;
        logic [7:0] b;
        in_chk    = 1'b0;
        stall_cnt = 0;
        forever begin
            @(negedge ck);
            if (in_chk) begin
                in_chk = 1'b0;
                if (exp_load_q.size() == 0) underflow("in_data");
                else begin b = exp_load_q.pop_front(); check("in_data", load_d, b); end
            end
            if (ld_strobe) begin
                if (exp_load_q.size() == 0) underflow("load_data");
                else begin b = exp_load_q.pop_front(); check("load_data", load_d, b); end
            end
            if (io_in_ready && io_in_valid) in_chk = 1'b1;
            if (io_out_valid && io_out_ack) begin
                if (exp_out_q.size() == 0) underflow("out_data");
                else begin b = exp_out_q.pop_front(); check("out_data", io_out_d, b); end
            end
            if (stall) begin
                stall_cnt++;
            end else if (stall_cnt > 0) begin
                if (exp_stall_q.size() == 0) underflow("stall_len");
                else begin e = exp_stall_q.pop_front(); check("stall_len", stall_cnt, e); end
                stall_cnt = 0;
            end
            if (res) begin
                check("handshake_vs_stall", {io_in_ready, io_out_valid, stall},
                      io_in_ready ? 3'b101 : (io_out_valid ? 3'b011 : {2'b00, stall}));
                check("stall_decode", stall, io_in_ready | io_out_valid);
            end
        end
    end

    initial begin
        res = 1'b0; addr = 8'h00; store_d = 8'h00; io_in_d = 8'h00;
        set_idle();
        last_load = 8'h00;
        repeat (3) @(posedge ck);
        #1;
        check("rst_load_d", load_d, 0);
        check("rst_stall", stall, 0);
        check("rst_in_ready", io_in_ready, 0);
        check("rst_out_valid", io_out_valid, 0);
        check("rst_out_d", io_out_d, 0);
        res = 1'b1;
        tick();

        do_store(8'h10, 8'hA5);
        do_load(8'h10);
        do_in(3, 8'h3C);
        do_in(0, 8'h96);
        do_out(8'h7E, 2);

        // Reset while an OUT is waiting for its ack.
        exp_stall_q.push_back(1);
        ck2 = 1'b1; kind = 4'b0011; fn2 = 2'b11; store_d = 8'h55;
        tick();
        tick();
        res = 1'b0;
        #1;
        check("arst_out_valid", io_out_valid, 0);
        check("arst_stall", stall, 0);
        check("arst_out_d", io_out_d, 0);
        check("arst_load_d", load_d, 0);
        set_idle();
        last_load = 8'h00;
        tick();
        res = 1'b1;
        tick();
        do_load(8'h10);

        do_bad(1'b1, 8'h10, 8'hFF);
        do_load(8'h10);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0: do_store(8'($urandom), 8'($urandom));
                1: begin
                    if (wr_list.size() == 0) do_store(8'($urandom), 8'($urandom));
                    else do_load(wr_list[$urandom_range(0, wr_list.size() - 1)]);
                end
                2: do_in($urandom_range(0, 4), 8'($urandom));
                3: do_out(8'($urandom), $urandom_range(0, 3));
                4: do_bad(1'b1, wr_list.size() == 0 ? 8'h10 : wr_list[$urandom_range(0, wr_list.size() - 1)],
                          8'($urandom));
                default: do_bad(1'b0, 8'($urandom), 8'($urandom));
            endcase
        end

        repeat (4) tick();
        check("load_queue_drained", exp_load_q.size(), 0);
        check("out_queue_drained", exp_out_q.size(), 0);
        check("stall_queue_drained", exp_stall_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_io_unit.md
# mem_io_unit

Data-side memory and I/O unit of the pP 8-bit processor; the other end of the register file's load/store path. It consumes `store_d` and the effective address, holds the data RAM, and returns `load_d` to the register file's write-back phase. Instruction kind `4'b0011` (mem_IO) is decoded by `fn2` into load, store, port input and port output. Port transfers use a valid/ready handshake and stall the sequencer until they complete.

## Interface
- `ADDR_W`, 8, data RAM address width; depth = 2**ADDR_W bytes, 8-bit words
- `ck` in 1 system clock, all state updates on rising edge
- `res` in 1 asynchronous active-low reset
- `ck2` in 1 phase flag from sequencer: 1 = operand/access phase, 0 = write-back phase
- `kind` in 4 instruction kind; only `4'b0011` acts
- `fn2` in 2 sub-op: 00 load, 01 store, 10 IN, 11 OUT
- `addr` in ADDR_W effective address, RAM index
- `store_d` in 8 store/OUT data from register file
- `load_d` out 8 load/IN result to register file
- `stall` out 1 freeze request to sequencer; sequencer holds `ck2` while high
- `io_in_d` in 8 input port data
- `io_in_valid` in 1 input port data valid
- `io_in_ready` out 1 unit ready to accept input byte
- `io_out_d` out 8 output port data
- `io_out_valid` out 1 output byte valid
- `io_out_ack` in 1 peripheral accepted output byte

## Operation
- FSM states: IDLE, IN_WAIT, OUT_WAIT, DONE.
- `mem_op` = (`kind`==4'b0011).
- IDLE, edge with `mem_op` & `ck2`=1:
  - fn2=00: `load_q` <= RAM[`addr`]; stay IDLE.
  - fn2=10: go IN_WAIT.
  - fn2=11: `io_out_d` <= `store_d`; go OUT_WAIT.
  - fn2=01: no action in this phase.
- Any state, edge with `mem_op` & fn2=01 & `ck2`=0: RAM[`addr`] <= `store_d`.
- IN_WAIT: `io_in_ready`=1; on edge with `io_in_valid`=1: `load_q` <= `io_in_d`, go DONE; otherwise stay.
- OUT_WAIT: `io_out_valid`=1; on edge with `io_out_ack`=1 go DONE; otherwise stay.
- DONE: one cycle, no new access started; go IDLE. Blocks re-trigger while `ck2` is still 1.
- `stall` = state is IN_WAIT or OUT_WAIT; decoded from state register, glitch-free.
- `load_d` = `load_q`, registered; holds until next load/IN.
- `kind`≠0011: no RAM write, no state change, `load_q` held.
- Reset: state IDLE; `load_q`, `io_out_d` = 0; `stall`, `io_in_ready`, `io_out_valid` = 0. RAM contents are not reset; reads before writes are undefined.

## Timing
- Load: address sampled at edge with `ck2`=1; `load_d` valid after that edge, stable for the whole `ck2`=0 phase. The register file captures it on the following edge.
- Store: write on the `ck2`=0 edge. A load of the same address in the next instruction returns the new data.
- IN: IDLE→IN_WAIT at the access edge; minimum one IN_WAIT cycle even if `io_in_valid` is already high. Data is captured on the first edge with valid; then DONE. `stall` is high for N≥1 cycles.
- OUT: `io_out_d` is stable from OUT_WAIT entry until the next OUT. `io_out_valid` falls the cycle after the ack edge.
- Async reset mid-IN_WAIT/OUT_WAIT: immediate IDLE; handshake outputs drop; no data captured.
- Peripheral must not expect `io_in_ready` or `io_out_valid` to stay high after its valid or ack edge.

## Structure
- Shared package `pp_defs`:
  - `KIND_MEM_IO` = 4'b0011 and the other kind codes.
  - `FN2_LOAD`/`FN2_STORE`/`FN2_IN`/`FN2_OUT`.
  - FSM state encodings.
- Sub-module `data_ram`: single-port, synchronous write, synchronous read, no reset, parameter ADDR_W.
- FSM and port registers in `mem_io_unit`.

## Test plan
- Store 8'hA5 to addr 8'h10 (`ck2`=0), then load 8'h10 (`ck2`=1) → `load_d`=8'hA5 after the access edge, `stall` never high.
- IN with `io_in_valid` low for 3 cycles, then `io_in_d`=8'h3C valid → `stall` high 4 cycles, `load_d`=8'h3C, `io_in_ready` low in DONE.
- IN with `io_in_valid` already high → exactly 1 stall cycle, captured data correct, no second capture in DONE.
- OUT `store_d`=8'h7E, ack after 2 cycles → `io_out_d`=8'h7E, `io_out_valid` high 3 cycles, `stall` high 3 cycles.
- Assert `res` low during OUT_WAIT → `io_out_valid`, `stall`=0 immediately, `io_out_d`=0; subsequent load works.
- `kind`=4'b0000 with fn2=01 and `ck2`=0 → RAM unchanged (readback returns the prior value).
